// File: rtl/data_sram_responder.sv
// Data-memory responder for the CPU load/store sram-like port.
// In-order queue with fixed response latency and byte-masked word array.
module data_sram_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        resp_stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(LAT + 1);
  localparam int NW = 2 ** ADDR_W;

  localparam logic [WW-1:0] WINIT = WW'(LAT - 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     head_nx;
  logic [PW-1:0]     tail_nx;
  logic [CW-1:0]     count;

  logic              q_wr    [DEPTH];
  logic [ADDR_W-1:0] q_idx   [DEPTH];
  logic [31:0]       q_wdata [DEPTH];
  logic [3:0]        q_mask  [DEPTH];
  logic [WW-1:0]     q_wait  [DEPTH];

  logic [31:0]       mem [NW];

  logic [3:0]        mask;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              fire;
  logic              unused_addr;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign addr_ok = (count != FULL);
  assign accept  = req & addr_ok;
  assign fire    = (count != '0)
                 & (q_wait[head] == '0)
                 & ~resp_stall;

  assign head_nx = (head == PLAST) ? '0 : head + PW'(1);
  assign tail_nx = (tail == PLAST) ? '0 : tail + PW'(1);

  // Byte-lane mask; misaligned accesses get an empty mask.
  always_comb begin
    mask = 4'b0000;
    unique case (1'b1)
      size == 2'd0: begin
        mask = 4'b0001 << addr[1:0];
      end
      size == 2'd1: begin
        if (!addr[0]) begin
          mask = addr[1] ? 4'b1100 : 4'b0011;
        end
      end
      default: begin
        if (addr[1:0] == 2'b00) begin
          mask = 4'b1111;
        end
      end
    endcase
  end

  // Queue payload and per-entry latency countdown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_wait[i] != '0) begin
        q_wait[i] <= q_wait[i] - WW'(1);
      end
    end
    if (accept) begin
      q_wr[tail]    <= wr;
      q_idx[tail]   <= idx;
      q_wdata[tail] <= wdata;
      q_mask[tail]  <= mask;
      q_wait[tail]  <= WINIT;
    end
  end

  // Pointers, occupancy and the registered response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= fire;
      if (fire) begin
        rdata <= q_wr[head] ? '0 : mem[q_idx[head]];
        head  <= head_nx;
      end
      if (accept) begin
        tail <= tail_nx;
      end
      unique case ({accept, fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array: not reset, written by the head write when it fires.
  always_ff @(posedge clk) begin
    if (fire && q_wr[head]) begin
      for (int b = 0; b < 4; b++) begin
        if (q_mask[head][b]) begin
          mem[q_idx[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
        end
      end
    end
  end

endmodule
